// File: rtl/seq_code_checker_pkg.sv
// Shared definitions for the serial code checker.
//   state_e   : controller state encoding (IDLE/COMPARE/REPORT/LOCK)
//   cnt_width : width of the consecutive-failure counter for a given MAX_TRIES
//   idx_width : width of the serial bit index for a given code width
package seq_code_checker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    REPORT  = 2'd2,
    LOCK    = 2'd3
  } state_e;

  // CNT_W helper: enough bits to hold 0..max_tries inclusive
  function automatic int unsigned cnt_width(input int unsigned max_tries);
    return $clog2(max_tries + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/eq.sv
// eq: 1-bit equality comparator cell shared by the serial checker.
//   a, b : bits to compare
//   o    : 1 when a == b
module eq (
  input  logic a,
  input  logic b,
  output logic o
);

  assign o = ~(a ^ b);

endmodule

// File: rtl/seq_code_checker_lockout_timer.sv
// Lockout down-counter: load arms it for LOCK_CYCLES cycles of en.
// Only built when LOCKOUT_EN is defined.
//   clk, rst   : clock, synchronous active-high reset
//   load       : reload counter (cycle before the lock period starts)
//   en         : count down while the controller is in LOCK
//   expired_c  : combinational, high in the last cycle of the lock period
`ifdef LOCKOUT_EN
module seq_code_checker_lockout_timer #(
  parameter int unsigned LOCK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(LOCK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Loaded with LOCK_CYCLES-1 so that count 0 marks the final lock cycle
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule
`endif

// File: rtl/seq_code_checker.sv
// Serial code verifier: compares an entered code against the stored key one
// bit per cycle through a single shared eq cell, with constant latency, and
// tracks consecutive failed attempts.
// Optional lockout after MAX_TRIES failures is enabled by defining LOCKOUT_EN.
//   clk, rst  : clock, synchronous active-high reset
//   key_load  : load key_in into the key register (IDLE only, beats start)
//   key_in    : new key value
//   start     : begin a check of code_in (IDLE only)
//   code_in   : entered code, sampled on accepted start
//   busy      : high while bits are being compared
//   done      : one-cycle pulse when match/fail_cnt are updated
//   match     : result of last check, cleared on accepted start
//   fail_cnt  : consecutive failure count, saturating at MAX_TRIES
//   locked    : lockout active (always 0 without LOCKOUT_EN)
module seq_code_checker
  import seq_code_checker_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              key_load,
  input  logic [WIDTH-1:0]                  key_in,
  input  logic                              start,
  input  logic [WIDTH-1:0]                  code_in,
  output logic                              busy,
  output logic                              done,
  output logic                              match,
  output logic [cnt_width(MAX_TRIES)-1:0]   fail_cnt,
  output logic                              locked
);

  localparam int unsigned CNT_W = cnt_width(MAX_TRIES);
  localparam int unsigned IDX_W = idx_width(WIDTH);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_TRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  // Reject unusable parameterisations at elaboration
  if ((WIDTH < 2) || (MAX_TRIES < 1) || (LOCK_CYCLES < 1)) begin : g_param_check
    $error("seq_code_checker: invalid parameters");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mis_q, mis_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] fail_inc_c;
  logic             code_bit_c, key_bit_c, bit_eq_c;

  // Shared comparator sees the current bit of code and key
  assign code_bit_c = code_q[idx_q];
  assign key_bit_c  = key_q[idx_q];

  eq u_eq (
    .a (code_bit_c),
    .b (key_bit_c),
    .o (bit_eq_c)
  );

  // Saturating increment of the failure counter
  assign fail_inc_c = (fail_q == MAX_CNT) ? fail_q : fail_q + CNT_W'(1);

`ifdef LOCKOUT_EN
  logic locked_q, locked_d;
  logic lock_load_c, lock_en_c, lock_expired_c;

  assign lock_en_c = (state_q == LOCK);

  seq_code_checker_lockout_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lockout_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (lock_load_c),
    .en        (lock_en_c),
    .expired_c (lock_expired_c)
  );
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    code_d  = code_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    done_d  = 1'b0;
    match_d = match_q;
    fail_d  = fail_q;
`ifdef LOCKOUT_EN
    locked_d    = locked_q;
    lock_load_c = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (key_load) begin
          key_d = key_in;
        end else if (start) begin
          code_d  = code_in;
          idx_d   = '0;
          mis_d   = 1'b0;
          match_d = 1'b0;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        // All bits always examined so timing does not leak the mismatch position
        mis_d = mis_q | ~bit_eq_c;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = REPORT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      REPORT: begin
        done_d  = 1'b1;
        match_d = ~mis_q;
        fail_d  = mis_q ? fail_inc_c : '0;
        state_d = IDLE;
`ifdef LOCKOUT_EN
        if (mis_q && (fail_inc_c == MAX_CNT)) begin
          state_d     = LOCK;
          locked_d    = 1'b1;
          lock_load_c = 1'b1;
        end
`endif
      end

      LOCK: begin
`ifdef LOCKOUT_EN
        if (lock_expired_c) begin
          fail_d   = '0;
          locked_d = 1'b0;
          state_d  = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == COMPARE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      code_q  <= '0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      fail_q  <= fail_d;
    end
  end

`ifdef LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign match    = match_q;
  assign fail_cnt = fail_q;

endmodule
